// File: rtl/rom_fetch_scheduler.sv
// rom_fetch_scheduler
//   Time-shares a single character ROM between the four display-digit address
//   sources. A bank of four 8-bit segment patterns is kept for scan_unit. Only
//   slots whose address changed, or that were invalidated, are fetched, and
//   they are served in round-robin order.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset, aborts any fetch in flight
//   addr_in    four slot addresses, slot0 in the top AW bits .. slot3 in the low AW bits
//   refresh    one-cycle pulse that invalidates every slot and forces a refetch
//   rom_addr   registered address to the shared ROM
//   rom_data   ROM read data, ROM_LAT cycles after rom_addr
//   sseg_bank  {slot0,slot1,slot2,slot3} segment patterns
//   valid      valid[3-s] set when slot s pattern matches its tag and is not invalidated
//   busy       a ROM fetch is in flight
module rom_fetch_scheduler #(
  parameter int         AW      = 6,
  parameter int         DEPTH   = 35,
  parameter int         ROM_LAT = 1,
  parameter logic [7:0] BLANK   = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4*AW-1:0] addr_in,
  input  logic            refresh,
  output logic [AW-1:0]   rom_addr,
  input  logic [7:0]      rom_data,
  output logic [31:0]     sseg_bank,
  output logic [3:0]      valid,
  output logic            busy
);

  localparam int CW = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    rr_ptr;
  logic [1:0]    cur;
  logic          stale;

  // Per-slot storage, indexed by slot number (slot0 = leftmost digit)
  logic [AW-1:0] tag  [4];
  logic [7:0]    pat  [4];
  logic [3:0]    vld;

  logic [AW-1:0] addr_s [4];
  logic [3:0]    need;
  logic [3:0]    need_eff;
  logic          capture;
  logic          cap_ok;
  logic          found;
  logic [1:0]    win;
  logic          issue;
  logic          oor;

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      addr_s[s] = addr_in[(3-s)*AW +: AW];
      need[s]   = ~vld[s] | (addr_s[s] != tag[s]);
    end
  end

  // A capture only marks the slot valid if no refresh hit the fetch and the
  // slot still asks for the address that was fetched; otherwise the pattern
  // is written but the slot keeps requesting service.
  assign capture = (state == WAIT) && (cnt == CW'(ROM_LAT));
  assign cap_ok  = capture && !stale && !refresh && (addr_s[cur] == tag[cur]);

  // Demand as seen after this edge, so a back-to-back issue on a capture edge
  // neither re-serves a slot that just completed nor misses a refresh.
  always_comb begin
    need_eff = need | {4{refresh}};
    if (capture) need_eff[cur] = ~cap_ok;
  end

  // Round-robin search starting just after the last slot served
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i + 1);
      if (!found && need_eff[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign issue = ((state == IDLE) || capture) && found;
  assign oor   = ({1'b0, addr_s[win]} >= DEPTH_V);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue && !oor) state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = (issue && !oor) ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rom_addr <= '0;
      rr_ptr   <= 2'd3;
      cur      <= 2'd0;
      cnt      <= '0;
      stale    <= 1'b0;
      vld      <= '0;
      for (int s = 0; s < 4; s++) begin
        tag[s] <= '0;
        pat[s] <= 8'hFF;
      end
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == WAIT);

      if (state == WAIT && !capture) cnt <= cnt + CW'(1);

      if (issue)                          stale <= 1'b0;
      else if (state == WAIT && refresh)  stale <= 1'b1;

      if (capture) begin
        pat[cur] <= rom_data;
        if (cap_ok) vld[cur] <= 1'b1;
      end

      if (issue) begin
        rr_ptr   <= win;
        tag[win] <= addr_s[win];
        if (oor) begin
          // Out-of-range address: blank the digit without touching the ROM
          pat[win] <= BLANK;
          vld[win] <= 1'b1;
        end else begin
          // Pattern is stale until the capture, so drop valid meanwhile
          rom_addr <= addr_s[win];
          cur      <= win;
          cnt      <= '0;
          vld[win] <= 1'b0;
        end
      end

      // refresh overrides any valid set on the same edge
      if (refresh) vld <= '0;
    end
  end

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      valid[3-s]             = vld[s];
      sseg_bank[(3-s)*8 +: 8] = pat[s];
    end
  end

endmodule

// File: tb/tb_rom_fetch_scheduler.sv
module tb_rom_fetch_scheduler;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*AW-1:0] addr_in;
  logic            refresh = 1'b0;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data = 8'h00;
  logic [31:0]     sseg_bank;
  logic [3:0]      valid;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q [$];

  rom_fetch_scheduler #(.AW(AW), .DEPTH(35), .ROM_LAT(1), .BLANK(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_in   (addr_in),
    .refresh   (refresh),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sseg_bank (sseg_bank),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Character ROM contents: distinct, never all-ones
  function automatic logic [7:0] f(input logic [AW-1:0] a);
    return {2'b10, a};
  endfunction

  // Registered ROM, one cycle latency
  always @(posedge clk) rom_data <= f(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic [AW-1:0] a);
    addr_in[(3-s)*AW +: AW] = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a);
    exp_q.push_back(a);
  endtask

  task automatic check_issue(input string tag);
    logic [AW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed %0h expected <empty scoreboard>", tag, rom_addr);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(rom_addr), 32'(e));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    addr_in = {6'd22, 6'd16, 6'd27, 6'd29};
    tick();
    tick();
    chk("rst_sseg",  sseg_bank, 32'hFFFF_FFFF);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_addr",  32'(rom_addr), 32'd0);
    rst = 1'b0;

    // Initial fill: slots 0..3 on edges 0,2,4,6
    push(22); push(16); push(27); push(29);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_issue($sformatf("fill_issue%0d", k));
      tick();
    end
    tick();
    chk("fill_valid", 32'(valid), 32'hF);
    chk("fill_sseg",  sseg_bank, {f(22), f(16), f(27), f(29)});
    chk("fill_busy",  32'(busy), 32'd0);

    // Single address change on slot2
    set_slot(2, 6'd0);
    push(0);
    tick();
    check_issue("chg_issue");
    chk("chg_valid_fetch", 32'(valid), 32'b1101);
    tick();
    chk("chg_busy2", 32'(busy), 32'd1);
    chk("chg_old_pat", 32'(sseg_bank[15:8]), 32'(f(27)));
    tick();
    chk("chg_sseg",  sseg_bank, {f(22), f(16), f(0), f(29)});
    chk("chg_busy_end", 32'(busy), 32'd0);
    chk("chg_valid", 32'(valid), 32'hF);
    tick();
    chk("chg_idle", 32'(busy), 32'd0);

    // Refresh from idle, then slot1 address moves right after its issue
    refresh = 1'b1;
    push(29); push(22); push(16);
    tick();
    refresh = 1'b0;
    check_issue("ref_issue3");
    chk("ref_valid_clr", 32'(valid), 32'd0);
    tick(); tick();
    check_issue("ref_issue0");
    tick(); tick();
    check_issue("ref_issue1");
    set_slot(1, 6'd30);
    push(0); push(30);
    tick(); tick();
    chk("move_old_pat", 32'(sseg_bank[23:16]), 32'(f(16)));
    chk("move_valid", 32'(valid), 32'b1001);
    check_issue("move_issue2");
    tick(); tick();
    check_issue("move_refetch");
    tick(); tick();
    chk("move_valid_end", 32'(valid), 32'hF);
    chk("move_sseg", sseg_bank, {f(22), f(30), f(0), f(29)});
    chk("move_busy", 32'(busy), 32'd0);

    // Refresh coincides with slot0 capture
    set_slot(0, 6'd5);
    push(5);
    tick();
    check_issue("rc_issue0");
    tick();
    refresh = 1'b1;
    push(30); push(0); push(29); push(5);
    tick();
    refresh = 1'b0;
    chk("rc_valid", 32'(valid), 32'd0);
    chk("rc_pat0", 32'(sseg_bank[31:24]), 32'(f(5)));
    check_issue("rc_issue_s1");
    tick(); tick();
    check_issue("rc_issue_s2");
    tick(); tick();
    check_issue("rc_issue_s3");
    tick(); tick();
    check_issue("rc_issue_s0");
    tick(); tick();
    chk("rc_valid_end", 32'(valid), 32'hF);
    chk("rc_busy", 32'(busy), 32'd0);
    chk("rc_sseg", sseg_bank, {f(5), f(30), f(0), f(29)});

    // Out-of-range address on slot3
    set_slot(3, 6'd40);
    tick();
    chk("oor_pat",   32'(sseg_bank[7:0]), 32'hFF);
    chk("oor_valid", 32'(valid), 32'hF);
    chk("oor_busy",  32'(busy), 32'd0);
    chk("oor_addr",  32'(rom_addr), 32'd5);
    tick();
    chk("oor_busy2", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a fetch
    set_slot(2, 6'd7);
    push(7);
    tick();
    check_issue("ar_issue");
    #3 rst = 1'b1;
    #1;
    chk("ar_sseg",  sseg_bank, 32'hFFFF_FFFF);
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_busy",  32'(busy), 32'd0);
    chk("ar_addr",  32'(rom_addr), 32'd0);
    tick(); tick();
    rst = 1'b0;
    push(5); push(30); push(7);
    tick();
    check_issue("ar_restart0");
    tick(); tick();
    check_issue("ar_restart1");
    tick(); tick();
    check_issue("ar_restart2");
    tick(); tick();
    chk("ar_valid_end", 32'(valid), 32'hF);
    chk("ar_busy_end",  32'(busy), 32'd0);
    chk("ar_sseg_end",  sseg_bank, {f(5), f(30), f(7), 8'hFF});
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
